// File: rtl/ipm2t_hssthp_pll_rst_fsm_v1_5.sv
// HSSTHP PLL power-up/reset sequencer: powerdown, reset, lock qualification and retry.
// Optional retry limit with FAIL state is enabled by defining IPM2T_HSSTHP_PLL_RETRY_LIMIT_EN.
module ipm2t_hssthp_pll_rst_fsm_v1_5 #(
    parameter int FREE_CLOCK_FREQ   = 100,
    parameter int P_PD_US           = 2,
    parameter int P_RST_US          = 1,
    parameter int P_LOCK_TIMEOUT_US = 500,
    parameter int P_LOCK_STABLE_CYC = 256,
    parameter int P_MAX_RETRY       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pll_pd,
    input  logic       i_pll_rst,
    input  logic       i_pll_lock,
    output logic       PLL_POWERDOWN,
    output logic       PLL_RST,
    output logic       o_pll_done,
    output logic       o_pll_lock_loss,
    output logic [3:0] o_retry_cnt,
    output logic       o_pll_fail
);

    localparam int PD_CNT = P_PD_US * FREE_CLOCK_FREQ;
    localparam int RST_CNT = P_RST_US * FREE_CLOCK_FREQ;
    localparam int TO_CNT = P_LOCK_TIMEOUT_US * FREE_CLOCK_FREQ;
    localparam logic [19:0] PD_LAST = 20'(PD_CNT - 1);
    localparam logic [19:0] RST_LAST = 20'(RST_CNT - 1);
    localparam logic [19:0] TO_LAST = 20'(TO_CNT - 1);
    localparam logic [8:0] LOCK_LAST = 9'(P_LOCK_STABLE_CYC - 1);
`ifdef IPM2T_HSSTHP_PLL_RETRY_LIMIT_EN
    localparam logic [3:0] RETRY_LAST = 4'(P_MAX_RETRY - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PD   = 3'd1,
        S_RST  = 3'd2,
        S_WAIT = 3'd3,
`ifdef IPM2T_HSSTHP_PLL_RETRY_LIMIT_EN
        S_FAIL = 3'd5,
`endif
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] cntr_q, cntr_d;
    logic [8:0]  lock_cnt_q, lock_cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        sync1_q, sync2_q;
    logic        pd_q, pd_d;
    logic        prst_q, prst_d;
    logic        done_q, done_d;
    logic        loss_q, loss_d;
    logic        fail_q, fail_d;
    logic        lock_sync;

    assign lock_sync = sync2_q;

    always_comb begin
        state_d    = state_q;
        cntr_d     = cntr_q + 20'd1;
        lock_cnt_d = '0;
        retry_d    = retry_q;
        loss_d     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_PD;
            S_PD: if (cntr_q == PD_LAST) state_d = S_RST;
            S_RST: if (cntr_q == RST_LAST) state_d = S_WAIT;
            S_WAIT: begin
                if (lock_sync) begin
                    if (lock_cnt_q == LOCK_LAST) state_d = S_DONE;
                    else lock_cnt_d = (lock_cnt_q == 9'h1ff) ? lock_cnt_q : lock_cnt_q + 9'd1;
                end
                // A qualified lock beats a timeout landing on the same cycle.
                if (state_d == S_WAIT && cntr_q == TO_LAST) begin
                    retry_d = (retry_q == 4'hf) ? retry_q : retry_q + 4'd1;
`ifdef IPM2T_HSSTHP_PLL_RETRY_LIMIT_EN
                    state_d = (retry_q >= RETRY_LAST) ? S_FAIL : S_RST;
`else
                    state_d = S_RST;
`endif
                end
            end
            S_DONE: begin
                if (!lock_sync) begin
                    state_d = S_RST;
                    loss_d  = 1'b1;
                end
            end
`ifdef IPM2T_HSSTHP_PLL_RETRY_LIMIT_EN
            S_FAIL: state_d = S_FAIL;
`endif
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) cntr_d = '0;

        // External overrides apply in every legal non-IDLE state and pin the counter at 0.
        if (state_q != S_IDLE && state_d != S_IDLE && (i_pll_pd || i_pll_rst)) begin
            state_d    = i_pll_pd ? S_PD : S_RST;
            cntr_d     = '0;
            lock_cnt_d = '0;
            retry_d    = retry_q;
            loss_d     = 1'b0;
        end

        if (state_d == S_PD) retry_d = '0;

        pd_d   = 1'b0;
        prst_d = 1'b0;
        done_d = 1'b0;
        fail_d = 1'b0;
        case (state_d)
            S_IDLE, S_PD: begin
                pd_d   = 1'b1;
                prst_d = 1'b1;
            end
            S_RST: prst_d = 1'b1;
            S_DONE: done_d = 1'b1;
`ifdef IPM2T_HSSTHP_PLL_RETRY_LIMIT_EN
            S_FAIL: begin
                pd_d   = 1'b1;
                prst_d = 1'b1;
                fail_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cntr_q     <= '0;
            lock_cnt_q <= '0;
            retry_q    <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            pd_q       <= 1'b1;
            prst_q     <= 1'b1;
            done_q     <= 1'b0;
            loss_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cntr_q     <= cntr_d;
            lock_cnt_q <= lock_cnt_d;
            retry_q    <= retry_d;
            sync1_q    <= i_pll_lock;
            sync2_q    <= sync1_q;
            pd_q       <= pd_d;
            prst_q     <= prst_d;
            done_q     <= done_d;
            loss_q     <= loss_d;
            fail_q     <= fail_d;
        end
    end

    assign PLL_POWERDOWN   = pd_q;
    assign PLL_RST         = prst_q;
    assign o_pll_done      = done_q;
    assign o_pll_lock_loss = loss_q;
    assign o_retry_cnt     = retry_q;
    assign o_pll_fail      = fail_q;

endmodule
